// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding for the receiver and the transmitter.
// Bit timing is derived from clock frequency and baud rate by integer division.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int DEF_CLK_FREQ  = 50_000_000;
   localparam int DEF_BAUD      = 115200;
   localparam int DEF_DATA_BITS = 8;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

   function automatic int cnt_width(input int cpb);
      return (cpb > 1) ? $clog2(cpb) : 1;
   endfunction

   localparam int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);
   localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
   localparam int CNT_W        = cnt_width(CLKS_PER_BIT);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a delayed copy for edge detection.
// All flops reset to 1 so that reset looks like an idle line and never fakes a start edge.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic rx_s_d
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b1;
         rx_s   <= 1'b1;
         rx_s_d <= 1'b1;
      end else begin
         meta   <= rx;
         rx_s   <= meta;
         rx_s_d <= rx_s;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit single sampling, one-entry valid/ready output buffer.
// Completed bytes land in the buffer one clock after the stop-bit sample; a full buffer drops the new byte.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int BAUD      = DEF_BAUD,
   parameter int DATA_BITS = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HB  = half_bit(CPB);
   localparam int CW  = cnt_width(CPB);
   localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HB - 1);
   localparam logic [BW-1:0] IDX_LAST     = BW'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 rx_s_d;
   uart_state_t          state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 byte_done;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx     (rx),
      .rx_s   (rx_s),
      .rx_s_d (rx_s_d)
   );

   // Frame FSM; byte_done and frame_err are single-cycle registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (rx_s_d && !rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == CNT_HALF_END) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_BIT_END) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[DATA_BITS-1:1]};
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_BIT_END) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (rx_s) begin
                     byte_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // shift cannot change before DATA is re-entered, so it is still valid while byte_done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   err_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(frame_err && overrun));

endmodule
